a_register_block: RTL and testbench

Upstream A-operand input stage of the PIRDSP slice: selects between the fabric input A and the cascade input ACIN and passes the value through a configurable 0/1/2-stage pipeline (A1, A2). It drives the 27-bit A2A1 operand into the D-register/pre-adder stage, the 30-bit A_ALU operand toward the ALU, and ACOUT to the next slice. Static configuration (5 bits) is loaded through the slice's serial configuration chain, the same way as every other block in the slice.

---
 rtl/a_register_block_pkg.sv | 37 +++
 rtl/a_register_block_pipe_reg.sv | 39 +++
 rtl/a_register_block.sv | 100 ++++++++++
 tb/tb_a_register_block.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_register_block_pkg.sv
// Shared constants for the A-operand input stage: default widths, AREG encodings
// and the bit order of the 5-bit serial configuration word.
package a_register_block_pkg;

    localparam int A_WIDTH_DEF  = 30;
    localparam int AD_WIDTH_DEF = 27;
    localparam int CFG_LEN      = 5;

    // Position of each field in the configuration shift register (bit 0 shifts in first).
    localparam int CFG_A_INPUT  = 0;
    localparam int CFG_AREG_LO  = 1;
    localparam int CFG_AREG_HI  = 2;
    localparam int CFG_ACASCREG = 3;
    localparam int CFG_RSTA_INV = 4;

    typedef enum logic [1:0] {
        AREG_COMB = 2'd0,
        AREG_ONE  = 2'd1,
        AREG_TWO  = 2'd2
    } areg_e;

    // 2'b11 aliases to two stages; a frozen input stage always uses two stages.
    function automatic areg_e eff_areg(input logic [1:0] raw, input logic freeze);
        areg_e r;
        if (freeze) begin
            r = AREG_TWO;
        end else begin
            case (raw)
                2'd0:    r = AREG_COMB;
                2'd1:    r = AREG_ONE;
                default: r = AREG_TWO;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/a_register_block_pipe_reg.sv
// Width-parameterised pipeline register used for the A1 and A2 stages:
// asynchronous reset, synchronous clear with priority over the clock enable.
module a_pipe_reg #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state: clear beats enable, otherwise hold.
    always_comb begin
        if (clr) begin
            q_d = {WIDTH{1'b0}};
        end else if (ce) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/a_register_block.sv
// A-operand input stage: A/ACIN select, 0/1/2-stage pipeline, output muxing
// and the serially loaded static configuration.
module a_register_block
    import a_register_block_pkg::*;
#(
    parameter int   A_WIDTH       = A_WIDTH_DEF,
    parameter int   AD_WIDTH      = AD_WIDTH_DEF,
    parameter logic input_freezed = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [A_WIDTH-1:0]  A,
    input  logic [A_WIDTH-1:0]  ACIN,
    input  logic                CEA1,
    input  logic                CEA2,
    input  logic                RSTA,
    input  logic                INMODE0,
    output logic [AD_WIDTH-1:0] A2A1,
    output logic [A_WIDTH-1:0]  A_ALU,
    output logic [A_WIDTH-1:0]  ACOUT,
    input  logic                configuration_input,
    input  logic                configuration_enable,
    output logic                configuration_output
);

    logic [CFG_LEN-1:0] cfg_q;
    logic [CFG_LEN-1:0] cfg_d;
    areg_e              areg_s;
    logic               is_two_s;
    logic               rsta_x_s;
    logic [A_WIDTH-1:0] a_sel_s;
    logic [A_WIDTH-1:0] a1_s;
    logic [A_WIDTH-1:0] a2_s;
    logic [A_WIDTH-1:0] a2_d_s;
    logic [A_WIDTH-1:0] a2a1_src_s;

    // Config chain next-state: shift toward IS_RSTA_INVERTED while enabled.
    always_comb begin
        if (configuration_enable) begin
            cfg_d = {cfg_q[CFG_LEN-2:0], configuration_input};
        end else begin
            cfg_d = cfg_q;
        end
    end

    // Config chain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= {CFG_LEN{1'b0}};
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign configuration_output = cfg_q[CFG_RSTA_INV];
    assign areg_s   = eff_areg({cfg_q[CFG_AREG_HI], cfg_q[CFG_AREG_LO]}, input_freezed);
    assign is_two_s = (areg_s == AREG_TWO);
    assign rsta_x_s = RSTA ^ cfg_q[CFG_RSTA_INV];
    assign a_sel_s  = cfg_q[CFG_A_INPUT] ? ACIN : A;
    assign a2_d_s   = is_two_s ? a1_s : a_sel_s;

    // A1 only moves in two-stage mode; A2 keeps running in every mode.
    a_pipe_reg #(.WIDTH(A_WIDTH)) u_a1 (
        .clk   (clk),
        .reset (reset),
        .clr   (is_two_s & rsta_x_s),
        .ce    (is_two_s & CEA1),
        .d     (a_sel_s),
        .q     (a1_s)
    );

    a_pipe_reg #(.WIDTH(A_WIDTH)) u_a2 (
        .clk   (clk),
        .reset (reset),
        .clr   (rsta_x_s),
        .ce    (CEA2),
        .d     (a2_d_s),
        .q     (a2_s)
    );

    // Output muxing.
    always_comb begin
        case (areg_s)
            AREG_COMB: A_ALU = a_sel_s;
            default:   A_ALU = a2_s;
        endcase
        if (is_two_s && cfg_q[CFG_ACASCREG]) begin
            ACOUT = a1_s;
        end else begin
            ACOUT = A_ALU;
        end
        if (is_two_s && INMODE0) begin
            a2a1_src_s = a1_s;
        end else begin
            a2a1_src_s = A_ALU;
        end
        A2A1 = a2a1_src_s[AD_WIDTH-1:0];
    end

endmodule

// File: tb/tb_a_register_block.sv
// Self-checking bench for a_register_block: a normal and an input_freezed instance
// driven with the same stimulus and compared against a behavioural model.
module tb_a_register_block;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] a, acin;
    logic        cea1, cea2, rsta, inmode0, cfg_in, cfg_en;
    logic [26:0] a2a1  [2];
    logic [29:0] alu   [2];
    logic [29:0] acout [2];
    logic        cfgo  [2];

    int n_pass  = 0;
    int n_total = 0;

    // Model state: configuration fields and pipeline contents per instance.
    logic        m_ain, m_casc, m_inv;
    logic [1:0]  m_areg;
    logic [29:0] m_a1 [2];
    logic [29:0] m_a2 [2];

    always #5 clk = ~clk;

    a_register_block #(.input_freezed(1'b0)) dut0 (
        .clk(clk), .reset(reset), .A(a), .ACIN(acin), .CEA1(cea1), .CEA2(cea2),
        .RSTA(rsta), .INMODE0(inmode0), .A2A1(a2a1[0]), .A_ALU(alu[0]), .ACOUT(acout[0]),
        .configuration_input(cfg_in), .configuration_enable(cfg_en),
        .configuration_output(cfgo[0])
    );

    a_register_block #(.input_freezed(1'b1)) dut1 (
        .clk(clk), .reset(reset), .A(a), .ACIN(acin), .CEA1(cea1), .CEA2(cea2),
        .RSTA(rsta), .INMODE0(inmode0), .A2A1(a2a1[1]), .A_ALU(alu[1]), .ACOUT(acout[1]),
        .configuration_input(cfg_in), .configuration_enable(cfg_en),
        .configuration_output(cfgo[1])
    );

    function automatic logic [1:0] m_stages(input int k);
        if (k == 1 || m_areg == 2'd3) return 2'd2;
        return m_areg;
    endfunction

    function automatic logic [29:0] m_sel();
        return m_ain ? acin : a;
    endfunction

    // Expected {A_ALU, ACOUT, A2A1, configuration_output} for instance k.
    function automatic logic [87:0] m_expect(input int k);
        logic [29:0] e_alu, e_ac, e_ad;
        e_alu = (m_stages(k) == 2'd0) ? m_sel() : m_a2[k];
        e_ac  = (m_stages(k) == 2'd2 && m_casc) ? m_a1[k] : e_alu;
        e_ad  = (m_stages(k) == 2'd2 && inmode0) ? m_a1[k] : e_alu;
        return {e_alu, e_ac, e_ad[26:0], m_inv};
    endfunction

    function automatic logic [87:0] dut_out(input int k);
        return {alu[k], acout[k], a2a1[k], cfgo[k]};
    endfunction

    task automatic model_reset();
        m_ain = 1'b0; m_casc = 1'b0; m_inv = 1'b0; m_areg = 2'd0;
        for (int k = 0; k < 2; k++) begin
            m_a1[k] = 30'd0;
            m_a2[k] = 30'd0;
        end
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_step();
        logic        clr;
        logic [29:0] sel, n1, n2;
        clr = rsta ^ m_inv;
        sel = m_sel();
        for (int k = 0; k < 2; k++) begin
            n1 = m_a1[k];
            if (m_stages(k) == 2'd2) begin
                if (clr) n1 = 30'd0;
                else if (cea1) n1 = sel;
            end
            if (clr) n2 = 30'd0;
            else if (cea2) n2 = (m_stages(k) == 2'd2) ? m_a1[k] : sel;
            else n2 = m_a2[k];
            m_a1[k] = n1;
            m_a2[k] = n2;
        end
        if (cfg_en) begin
            m_inv  = m_casc;
            m_casc = m_areg[1];
            m_areg = {m_areg[0], m_ain};
            m_ain  = cfg_in;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Shift a full configuration word; the first bit ends in IS_RSTA_INVERTED.
    task automatic load_cfg(input logic inv, input logic casc, input logic [1:0] ar, input logic ain);
        logic [4:0] bits;
        bits = {inv, casc, ar[1], ar[0], ain};
        cfg_en = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            cfg_in = bits[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; a = 30'h0ABCDEF1; acin = 30'd0; cea1 = 1'b0; cea2 = 1'b0;
        rsta = 1'b0; inmode0 = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (alu[0] !== 30'h0ABCDEF1) $display("FAIL reset_alu got %h expected %h", alu[0], 30'h0ABCDEF1);
        else n_pass++;
        n_total++;
        if (acout[0] !== 30'h0ABCDEF1) $display("FAIL reset_acout got %h expected %h", acout[0], 30'h0ABCDEF1);
        else n_pass++;
        n_total++;
        if (a2a1[0] !== 27'h2BCDEF1) $display("FAIL reset_a2a1 got %h expected %h", a2a1[0], 27'h2BCDEF1);
        else n_pass++;
        n_total++;
        if (cfgo[0] !== 1'b0 || alu[1] !== 30'd0) $display("FAIL reset_cfgo_frozen got %b/%h expected 0/0", cfgo[0], alu[1]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_config_load();
        logic [4:0] bits;
        bits = 5'b01101;
        cfg_en = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            cfg_in = bits[i];
            tick();
            n_total++;
            if (cfgo[0] !== m_inv) $display("FAIL cfg_shift%0d got %b expected %b", i, cfgo[0], m_inv);
            else n_pass++;
        end
        cfg_en = 1'b0;
        acin = 30'h155; a = 30'($urandom); cea1 = 1'b1; cea2 = 1'b1; rsta = 1'b0;
        tick();
        n_total++;
        if (acout[0] !== 30'h155) $display("FAIL cfg_acout_1edge got %h expected %h", acout[0], 30'h155);
        else n_pass++;
        tick();
        n_total++;
        if (alu[0] !== 30'h155) $display("FAIL cfg_alu_2edge got %h expected %h", alu[0], 30'h155);
        else n_pass++;
    endtask

    task automatic test_inmode();
        load_cfg(1'b0, 1'b0, 2'b10, 1'b0);
        inmode0 = 1'b1; cea1 = 1'b1; cea2 = 1'b1; rsta = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            a = 30'(v); acin = 30'($urandom);
            tick();
        end
        n_total++;
        if (a2a1[0] !== 27'd3 || alu[0] !== 30'd2) $display("FAIL inmode_ahead got %h/%h expected 3/2", a2a1[0], alu[0]);
        else n_pass++;
        inmode0 = 1'b0;
        #1;
        n_total++;
        if (a2a1[0] !== 27'd2) $display("FAIL inmode_off got %h expected %h", a2a1[0], 27'd2);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            a = 30'($urandom); acin = 30'($urandom); inmode0 = 1'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (dut_out(k) !== m_expect(k)) $display("FAIL inmode_stream dut%0d got %h expected %h", k, dut_out(k), m_expect(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_ce_rst();
        logic [29:0] v;
        load_cfg(1'b0, 1'b0, 2'b01, 1'b0);
        v = 30'($urandom) | 30'h1;
        a = v; cea2 = 1'b1; rsta = 1'b0;
        tick();
        n_total++;
        if (alu[0] !== v) $display("FAIL ce_load got %h expected %h", alu[0], v);
        else n_pass++;
        cea2 = 1'b0; a = ~v;
        tick();
        n_total++;
        if (alu[0] !== v) $display("FAIL ce_hold got %h expected %h", alu[0], v);
        else n_pass++;
        cea2 = 1'b1; rsta = 1'b1;
        tick();
        n_total++;
        if (alu[0] !== 30'd0) $display("FAIL rsta_priority got %h expected 0", alu[0]);
        else n_pass++;
        rsta = 1'b0;
        load_cfg(1'b1, 1'b0, 2'b01, 1'b0);
        a = 30'($urandom) | 30'h1;
        tick();
        n_total++;
        if (alu[0] !== 30'd0) $display("FAIL rsta_inverted got %h expected 0", alu[0]);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dut_out(k) !== m_expect(k)) $display("FAIL ce_rst_model dut%0d got %h expected %h", k, dut_out(k), m_expect(k));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        load_cfg(1'b0, 1'b1, 2'b10, 1'b0);
        cea1 = 1'b1; cea2 = 1'b1; rsta = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 30'($urandom) | 30'h1;
            tick();
        end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (alu[0] !== a || acout[0] !== a || cfgo[0] !== 1'b0) $display("FAIL async_reset got %h/%h/%b expected %h/%h/0", alu[0], acout[0], cfgo[0], a, a);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (dut_out(k) !== m_expect(k)) $display("FAIL async_reset_model dut%0d got %h expected %h", k, dut_out(k), m_expect(k));
            else n_pass++;
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_freeze();
        a = 30'd7; acin = 30'($urandom); cea1 = 1'b1; cea2 = 1'b1; rsta = 1'b0;
        #1;
        n_total++;
        if (alu[0] !== 30'd7 || alu[1] !== 30'd0) $display("FAIL freeze_0edge got %h/%h expected 7/0", alu[0], alu[1]);
        else n_pass++;
        tick();
        n_total++;
        if (alu[1] !== 30'd0) $display("FAIL freeze_1edge got %h expected 0", alu[1]);
        else n_pass++;
        tick();
        n_total++;
        if (alu[1] !== 30'd7) $display("FAIL freeze_2edge got %h expected 7", alu[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            a = 30'($urandom); acin = 30'($urandom);
            cea1 = 1'($urandom); cea2 = 1'($urandom);
            rsta = ($urandom_range(0, 7) == 0);
            inmode0 = 1'($urandom);
            cfg_en = ($urandom_range(0, 3) == 0);
            cfg_in = 1'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (dut_out(k) !== m_expect(k)) $display("FAIL random_comb%0d dut%0d got %h expected %h", i, k, dut_out(k), m_expect(k));
                else n_pass++;
            end
            tick();
        end
        cfg_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_config_load();
        test_inmode();
        test_ce_rst();
        test_async_reset();
        test_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
